read_arbiter: RTL and testbench
===============================

READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, read address width.
REQ-002 SHALL have parameter DATA_W, default 8, read data width.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width (beats = len+1).
REQ-004 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-005 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have, for N in {0,1}: mN_arvalid in 1; mN_araddr in ADDR_W; mN_arlen in LEN_W; mN_arid in ID_W; mN_arready out 1.
REQ-007 SHALL have, for N in {0,1}: mN_rvalid out 1; mN_rdata out DATA_W; mN_rresp out 1; mN_rlast out 1; mN_rready in 1.
REQ-008 SHALL have slave side: s_arvalid out 1; s_araddr out ADDR_W; s_arlen out LEN_W; s_arid out ID_W; s_arready in 1.
REQ-009 SHALL have slave side: s_rvalid in 1; s_rdata in DATA_W; s_rresp in 1; s_rlast in 1; s_rready out 1.
REQ-010 SHALL have grant out 2 (one-hot owner, 00 when idle), busy out 1, len_err out 1.

Function
REQ-011 SHALL implement states IDLE, ADDR, DATA; sequential logic only on posedge clk.
REQ-012 IDLE: select = requester with arvalid; both valid -> the one not in last_grant; mN_arready combinational = IDLE && selected N.
REQ-013 On arvalid&&arready in IDLE: latch addr/len/id, set grant, go ADDR; s_arvalid high the next cycle (1-cycle latency).
REQ-014 ADDR: s_arvalid=1 with latched fields stable; on s_arready go DATA and drop s_arvalid next cycle.
REQ-015 DATA: granted mN_rvalid/rdata/rresp/rlast = slave values combinationally; s_rready = granted mN_rready; non-granted mN_rvalid=0.
REQ-016 DATA: on s_rvalid&&s_rready&&s_rlast go IDLE, set last_grant to owner, clear grant.
REQ-017 mN_arready SHALL be 0 in ADDR and DATA; requests held meanwhile wait, no loss.
REQ-018 busy SHALL be 1 in ADDR and DATA, 0 in IDLE.
REQ-019 Beats without rready SHALL stall; s_rlast without s_rvalid SHALL be ignored.

Reset
REQ-020 rst at any edge, including mid-burst, SHALL force IDLE, grant=00, busy=0, len_err=0, last_grant=1 (m0 wins first tie), beat count=0; in-flight burst dropped.
REQ-021 After reset all arready/rvalid/s_arvalid/s_rready outputs SHALL be 0 until a new request.

Configuration
REQ-022 With ARB_BEATCHK_EN defined, SHALL count R handshakes in DATA (LEN_W+1 bits, cleared on grant).
REQ-023 With ARB_BEATCHK_EN, len_err SHALL pulse 1 cycle after the rlast handshake if count != latched len+1.
REQ-024 Without ARB_BEATCHK_EN, counter absent; len_err tied 0; port list unchanged.

Verification
REQ-025 m0 only, addr=0x40 len=3 id=5, s_arready after 2 cycles, 4 beats -> s_araddr=0x40, s_arlen=3, m0 gets 4 beats, grant 01->00.
REQ-026 m0 and m1 valid same cycle after reset -> m0 served first, then m1; next tie -> m0 again (alternating).
REQ-027 m1 asserts arvalid during m0 DATA -> m1_arready stays 0 until m0 rlast handshake, then m1 accepted next IDLE cycle.
REQ-028 m0_rready low 3 cycles mid-burst -> s_rready low 3 cycles, no beat lost or duplicated.
REQ-029 rst in DATA after beat 2 of 4 -> next cycle IDLE, grant=00, s_rready=0.
REQ-030 ARB_BEATCHK_EN, len=3, slave rlast on beat 2 -> len_err=1 one cycle; without macro len_err=0.

Source files
------------

// File: rtl/read_arbiter.sv
// read_arbiter: two-master AXI-style read-channel arbiter (optional ARB_BEATCHK_EN adds a beat-count check on len_err)
module read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W = 4,
  parameter int ID_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [ID_W-1:0]   m0_arid,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rresp,
  output logic              m0_rlast,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [ID_W-1:0]   m1_arid,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rresp,
  output logic              m1_rlast,
  input  logic              m1_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [ID_W-1:0]   s_arid,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rresp,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              len_err
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic owner, last_grant, sel, hs_ar, hs_r, in_data;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] len;
  logic [ID_W-1:0] id;
  // Arbitration picks the lone requester, or on a tie the master that did not own the last burst
  always_comb begin
    sel = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;
    hs_ar = state == IDLE && (m0_arvalid || m1_arvalid);
    in_data = state == DATA;
    hs_r = in_data && s_rvalid && s_rready;
  end
  assign m0_arready = hs_ar && !sel;
  assign m1_arready = hs_ar && sel;
  assign s_arvalid = state == ADDR;
  assign s_araddr = addr;
  assign s_arlen = len;
  assign s_arid = id;
  assign s_rready = in_data && (owner ? m1_rready : m0_rready);
  assign m0_rvalid = in_data && !owner && s_rvalid;
  assign m1_rvalid = in_data && owner && s_rvalid;
  assign m0_rlast = in_data && !owner && s_rlast;
  assign m1_rlast = in_data && owner && s_rlast;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  assign grant = state == IDLE ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign busy = state != IDLE;
  // Burst sequencing: latch the winning request, forward it, then pass data until the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      addr <= '0;
      len <= '0;
      id <= '0;
    end else if (hs_ar) begin
      state <= ADDR;
      owner <= sel;
      addr <= sel ? m1_araddr : m0_araddr;
      len <= sel ? m1_arlen : m0_arlen;
      id <= sel ? m1_arid : m0_arid;
    end else if (state == ADDR && s_arready) begin
      state <= DATA;
    end else if (hs_r && s_rlast) begin
      state <= IDLE;
      last_grant <= owner;
    end
  end
`ifdef ARB_BEATCHK_EN
  logic [LEN_W:0] cnt;
  // Count accepted beats and flag a burst whose final beat count disagrees with the requested length
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len_err <= 1'b0;
    end else begin
      cnt <= hs_ar ? '0 : hs_r ? cnt + (LEN_W+1)'(1) : cnt;
      len_err <= hs_r && s_rlast && (cnt + (LEN_W+1)'(1) != {1'b0, len} + (LEN_W+1)'(1));
    end
  end
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter: directed self-checking bench for read_arbiter
module tb_read_arbiter;
  logic clk = 0, rst = 1;
  logic m0_arvalid = 0, m0_arready, m0_rvalid, m0_rresp, m0_rlast, m0_rready = 0;
  logic [7:0] m0_araddr = 0, m0_rdata;
  logic [3:0] m0_arlen = 0, m0_arid = 0;
  logic m1_arvalid = 0, m1_arready, m1_rvalid, m1_rresp, m1_rlast, m1_rready = 0;
  logic [7:0] m1_araddr = 0, m1_rdata;
  logic [3:0] m1_arlen = 0, m1_arid = 0;
  logic s_arvalid, s_arready = 0, s_rvalid = 0, s_rresp = 0, s_rlast = 0, s_rready;
  logic [7:0] s_araddr, s_rdata = 0;
  logic [3:0] s_arlen, s_arid;
  logic [1:0] grant;
  logic busy, len_err;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  read_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arid(m0_arid), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arid(m1_arid), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1; m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic request(input int who, input logic [7:0] a, input logic [3:0] l, input logic [3:0] i);
    if (who == 0) begin m0_araddr = a; m0_arlen = l; m0_arid = i; m0_arvalid = 1; end
    else begin m1_araddr = a; m1_arlen = l; m1_arid = i; m1_arvalid = 1; end
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== (who == 0 ? 2'b10 : 2'b01)) begin
      failures++; $display("FAIL req_arready who=%0d got=%b exp=%b", who, {m0_arready, m1_arready}, (who == 0 ? 2'b10 : 2'b01));
    end
    @(negedge clk);
    if (who == 0) m0_arvalid = 0; else m1_arvalid = 0;
    #1;
    checks++;
    if ({grant, s_arvalid, s_araddr, s_arlen, s_arid} !== {(who == 0 ? 2'b01 : 2'b10), 1'b1, a, l, i}) begin
      failures++; $display("FAIL req_fwd who=%0d got=%h exp=%h", who, {grant, s_arvalid, s_araddr, s_arlen, s_arid}, {(who == 0 ? 2'b01 : 2'b10), 1'b1, a, l, i});
    end
  endtask

  task automatic serve(input int who, input int n);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0;
    for (int b = 0; b < n; b++) begin
      s_rvalid = 1; s_rdata = 8'(who * 16 + b); s_rlast = (b == n - 1);
      if (who == 0) m0_rready = 1; else m1_rready = 1;
      #1;
      checks++;
      if ({(who == 0 ? m0_rvalid : m1_rvalid), (who == 0 ? m1_rvalid : m0_rvalid), (who == 0 ? m0_rlast : m1_rlast), s_rready, m0_arready, m1_arready, busy}
          !== {1'b1, 1'b0, (b == n - 1), 1'b1, 1'b0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL beat_ctrl who=%0d beat=%0d got=%b", who, b,
          {(who == 0 ? m0_rvalid : m1_rvalid), (who == 0 ? m1_rvalid : m0_rvalid), (who == 0 ? m0_rlast : m1_rlast), s_rready, m0_arready, m1_arready, busy});
      end
      checks++;
      if ((who == 0 ? m0_rdata : m1_rdata) !== 8'(who * 16 + b)) begin
        failures++; $display("FAIL beat_data who=%0d beat=%0d got=%h exp=%h", who, b, (who == 0 ? m0_rdata : m1_rdata), 8'(who * 16 + b));
      end
      @(negedge clk);
    end
    s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({grant, busy, len_err, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready} !== 10'b0) begin
      failures++; $display("FAIL reset_state got=%b exp=0", {grant, busy, len_err, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    request(0, 8'h40, 4'd3, 4'd5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({s_arvalid, s_araddr, s_arlen, busy} !== {1'b1, 8'h40, 4'd3, 1'b1}) begin
        failures++; $display("FAIL addr_hold cyc=%0d got=%h", c, {s_arvalid, s_araddr, s_arlen, busy});
      end
    end
    serve(0, 4);
    #1;
    checks++;
    if ({grant, busy, s_arvalid, len_err} !== 5'b0) begin
      failures++; $display("FAIL single_end got=%b exp=0", {grant, busy, s_arvalid, len_err});
    end
  endtask

  task automatic test_tie();
    do_reset();
    m1_arvalid = 1; m1_araddr = 8'h80; m1_arlen = 1; m1_arid = 2;
    request(0, 8'h10, 4'd0, 4'd1);
    serve(0, 1);
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== 2'b01) begin
      failures++; $display("FAIL tie_second got=%b exp=01", {m0_arready, m1_arready});
    end
    @(negedge clk);
    m1_arvalid = 0;
    #1;
    checks++;
    if ({grant, s_araddr} !== {2'b10, 8'h80}) begin
      failures++; $display("FAIL tie_m1_grant got=%h exp=%h", {grant, s_araddr}, {2'b10, 8'h80});
    end
    serve(1, 2);
    m1_arvalid = 1;
    request(0, 8'h11, 4'd0, 4'd3);
    m1_arvalid = 0;
    serve(0, 1);
  endtask

  task automatic test_hold();
    @(negedge clk);
    request(0, 8'h50, 4'd2, 4'd4);
    m1_arvalid = 1; m1_araddr = 8'h90; m1_arlen = 0; m1_arid = 6;
    serve(0, 3);
    #1;
    checks++;
    if ({grant, m0_arready, m1_arready} !== 4'b0001) begin
      failures++; $display("FAIL hold_release got=%b exp=0001", {grant, m0_arready, m1_arready});
    end
    @(negedge clk);
    m1_arvalid = 0;
    #1;
    checks++;
    if ({grant, s_araddr, s_arid} !== {2'b10, 8'h90, 4'd6}) begin
      failures++; $display("FAIL hold_m1_fwd got=%h exp=%h", {grant, s_araddr, s_arid}, {2'b10, 8'h90, 4'd6});
    end
    serve(1, 1);
  endtask

  task automatic test_stall();
    logic [6:0] pat;
    int beat;
    pat = 7'b1100011;
    beat = 0;
    @(negedge clk);
    request(0, 8'h20, 4'd3, 4'd1);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; s_rlast = 1; s_rvalid = 0;
    @(negedge clk);
    s_rlast = 0;
    #1;
    checks++;
    if ({busy, grant} !== 3'b101) begin
      failures++; $display("FAIL lone_rlast got=%b exp=101", {busy, grant});
    end
    for (int i = 0; i < 7; i++) begin
      s_rvalid = 1; s_rdata = 8'(8'h30 + beat); s_rlast = (beat == 3); m0_rready = pat[i];
      #1;
      checks++;
      if ({m0_rvalid, s_rready, m0_rdata} !== {1'b1, pat[i], 8'(8'h30 + beat)}) begin
        failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, {m0_rvalid, s_rready, m0_rdata}, {1'b1, pat[i], 8'(8'h30 + beat)});
      end
      @(negedge clk);
      if (pat[i]) beat++;
    end
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1;
    checks++;
    if ({busy, grant} !== 3'b000) begin
      failures++; $display("FAIL stall_end got=%b exp=000", {busy, grant});
    end
  endtask

  task automatic test_len_err();
    logic exp;
`ifdef ARB_BEATCHK_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    @(negedge clk);
    request(0, 8'h60, 4'd3, 4'd7);
    serve(0, 2);
    #1;
    checks++;
    if ({len_err, busy} !== {exp, 1'b0}) begin
      failures++; $display("FAIL len_err_pulse got=%b exp=%b", {len_err, busy}, {exp, 1'b0});
    end
    @(negedge clk);
    #1;
    checks++;
    if (len_err !== 1'b0) begin
      failures++; $display("FAIL len_err_clear got=%b exp=0", len_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    request(1, 8'h70, 4'd3, 4'd9);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1; s_rdata = 8'(b); s_rlast = 0; m1_rready = 1;
      @(negedge clk);
    end
    s_rdata = 8'd2; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({grant, busy, s_rready, m1_rvalid, s_arvalid, len_err} !== 7'b0) begin
      failures++; $display("FAIL reset_mid got=%b exp=0", {grant, busy, s_rready, m1_rvalid, s_arvalid, len_err});
    end
    s_rvalid = 0; m1_rready = 0;
    m0_arvalid = 1; m1_arvalid = 1;
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== 2'b10) begin
      failures++; $display("FAIL reset_tie got=%b exp=10", {m0_arready, m1_arready});
    end
    m0_arvalid = 0; m1_arvalid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_hold();
    test_stall();
    test_len_err();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
